fx2_stream_writer: RTL and testbench

- Drains the 8-bit DAQ FIFO read port of the packetizer (fifo_out_data/fifo_out_empty/fifo_out_req) into the Cypress FX2 slave FIFO (EP6 IN, synchronous mode).
- clk_i drives the packetizer's fifo_out_clk and the FX2 IFCLK.
- Full packets auto-commit at PKT_BYTES. Partial packets are committed with PKTEND after an idle timeout or when streaming is disabled.

---
 rtl/fx2_writer_pkg.sv | 18 +
 rtl/fx2_flush_timer.sv | 41 ++++
 rtl/fx2_stream_writer.sv | 118 +++++++++++
 tb/tb_fx2_stream_writer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_writer_pkg.sv
// Shared constants for the FX2 slave-FIFO stream writer.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package fx2_writer_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_PKTEND = 2'd3;

  // FX2 FIFOADR value selecting EP6
  localparam logic [1:0] EP6_ADDR = 2'b10;

  localparam int DEF_PKT_BYTES      = 512;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/fx2_flush_timer.sv
// Saturating idle counter; done_o once TIMEOUT_CYCLES-1 counts have accumulated.
// Latency: done_o is a registered compare, valid the cycle after the last increment.
// Backpressure: none; clr_i has priority over en_i.
// Ports: clk_i, reset_i (async active-low), clr_i (clear), en_i (count), done_o.
module fx2_flush_timer
  import fx2_writer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (en_i && (timer_q != LAST)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign done_o = (timer_q == LAST);

endmodule

// File: rtl/fx2_stream_writer.sv
// Drains the 8-bit DAQ FIFO into FX2 EP6 slave FIFO; partial packets flushed by PKTEND.
// Latency: fifo_req_o to slwr low is 2 cycles; at most one byte per 3 cycles.
// Backpressure: FLAGB low stalls the byte in WRITE (data held) and blocks fetch/PKTEND in IDLE.
// Ports: clk_i/reset_i, en_i, fifo_empty_i/fifo_req_o/fifo_data_i (DAQ FIFO read side),
//        fx2_* (FX2 slave FIFO pins), pkt_count_o (committed packets), busy_o.
module fx2_stream_writer
  import fx2_writer_pkg::*;
#(
  parameter int PKT_BYTES      = DEF_PKT_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             fifo_empty_i,
  output logic             fifo_req_o,
  input  logic [7:0]       fifo_data_i,
  input  logic             fx2_full_n_i,
  output logic [7:0]       fx2_fd_o,
  output logic             fx2_slwr_n_o,
  output logic             fx2_pktend_n_o,
  output logic [1:0]       fx2_fifoadr_o,
  output logic             fx2_sloe_n_o,
  output logic [CNT_W-1:0] pkt_count_o,
  output logic             busy_o
);

  localparam int BW = $clog2(PKT_BYTES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_BYTES - 1);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]       fd_q, fd_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

  logic fetch_go;
  logic accept;
  logic tmr_done;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    fd_d        = fd_q;
    pkt_count_d = pkt_count_q;
    fetch_go    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // New data takes priority over a due flush; the write clears the timer.
        if (en_i && !fifo_empty_i && fx2_full_n_i) begin
          fetch_go = 1'b1;
          state_d  = ST_FETCH;
        end else if ((byte_cnt_q != '0) && fx2_full_n_i && (!en_i || tmr_done)) begin
          state_d = ST_PKTEND;
        end
      end
      ST_FETCH: begin
        // FIFO q is valid the cycle after the request
        fd_d    = fifo_data_i;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (fx2_full_n_i) begin
          accept  = 1'b1;
          state_d = ST_IDLE;
          if (byte_cnt_q == LAST_BYTE) begin
            // FX2 auto-commits the full packet
            byte_cnt_d  = '0;
            pkt_count_d = pkt_count_q + 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: begin // ST_PKTEND
        byte_cnt_d  = '0;
        pkt_count_d = pkt_count_q + 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      fd_q        <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      fd_q        <= fd_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  fx2_flush_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_flush_timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (accept || (state_q == ST_PKTEND)),
    .en_i   ((state_q == ST_IDLE) && (byte_cnt_q != '0)),
    .done_o (tmr_done)
  );

  // The request is a combinational IDLE decision; keep it quiet while reset is held.
  assign fifo_req_o     = fetch_go & reset_i;
  assign fx2_fd_o       = fd_q;
  assign fx2_slwr_n_o   = !((state_q == ST_WRITE) && fx2_full_n_i);
  assign fx2_pktend_n_o = !(state_q == ST_PKTEND);
  assign fx2_fifoadr_o  = EP6_ADDR;
  assign fx2_sloe_n_o   = 1'b1;
  assign pkt_count_o    = pkt_count_q;
  assign busy_o         = (state_q != ST_IDLE) || (byte_cnt_q != '0);

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Scoreboard bench for fx2_stream_writer: stimulus queues expected FX2 strobes and
// signal snapshots; a negedge monitor pops and compares them.
module tb_fx2_stream_writer;

  localparam int PKT = 512;
  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        fifo_empty_i;
  logic        fifo_req_o;
  logic [7:0]  fifo_data_i;
  logic        fx2_full_n_i;
  logic [7:0]  fx2_fd_o;
  logic        fx2_slwr_n_o;
  logic        fx2_pktend_n_o;
  logic [1:0]  fx2_fifoadr_o;
  logic        fx2_sloe_n_o;
  logic [15:0] pkt_count_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  fx2_stream_writer #(
    .PKT_BYTES     (PKT),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_req_o    (fifo_req_o),
    .fifo_data_i   (fifo_data_i),
    .fx2_full_n_i  (fx2_full_n_i),
    .fx2_fd_o      (fx2_fd_o),
    .fx2_slwr_n_o  (fx2_slwr_n_o),
    .fx2_pktend_n_o(fx2_pktend_n_o),
    .fx2_fifoadr_o (fx2_fifoadr_o),
    .fx2_sloe_n_o  (fx2_sloe_n_o),
    .pkt_count_o   (pkt_count_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    int sel;
    int exp;
  } snap_t;

  logic [7:0] fifo_q[$];   // DAQ FIFO model contents
  logic [8:0] exp_q[$];    // expected strobes: {is_pktend, data}
  snap_t      snap_q[$];   // expected signal snapshots

  // Written only by the monitor
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr = 0;
  int last_pe = 0;
  int req_cnt = 0;
  int wr_total = 0;
  bit sp_prev = 1'b0;

  // Written only by the stimulus
  bit chk_spacing = 1'b0;
  int req_seen = 0;

  function automatic string snap_name(input int sel);
    case (sel)
      0:       return "slwr_n";
      1:       return "pktend_n";
      2:       return "fifo_req";
      3:       return "fifoadr";
      4:       return "sloe_n";
      5:       return "pkt_count";
      6:       return "busy";
      7:       return "fd";
      8:       return "pktend_gap";
      9:       return "req_count";
      10:      return "drain_left";
      default: return "write_count";
    endcase
  endfunction

  function automatic int snap_act(input int sel);
    case (sel)
      0:       return int'(fx2_slwr_n_o);
      1:       return int'(fx2_pktend_n_o);
      2:       return int'(fifo_req_o);
      3:       return int'(fx2_fifoadr_o);
      4:       return int'(fx2_sloe_n_o);
      5:       return int'(pkt_count_o);
      6:       return int'(busy_o);
      7:       return int'(fx2_fd_o);
      8:       return last_pe - last_wr;
      9:       return req_cnt;
      10:      return exp_q.size();
      default: return wr_total;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    logic [8:0] e;
    snap_t s;
    int a;
    cyc++;
    if (!chk_spacing) sp_prev = 1'b0;
    if (reset_i) begin
      if (fifo_req_o) begin
        req_cnt++;
        n_chk++;
        if (fifo_empty_i) begin
          n_fail++;
          $display("FAIL req_while_empty: got req=1 empty=1 required no request at cycle %0d", cyc);
        end
      end
      if (!fx2_slwr_n_o || !fx2_pktend_n_o) begin
        n_chk++;
        if (!fx2_slwr_n_o && !fx2_pktend_n_o) begin
          n_fail++;
          $display("FAIL strobe_overlap: got slwr_n=0 pktend_n=0 required at most one low, cycle %0d", cyc);
        end
      end
      if (!fx2_slwr_n_o) begin
        wr_total++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got write of %02h required no strobe", fx2_fd_o);
        end else begin
          e = exp_q.pop_front();
          if (e != {1'b0, fx2_fd_o}) begin
            n_fail++;
            $display("FAIL write_data: got write %02h required %s %02h", fx2_fd_o,
                     e[8] ? "pktend" : "write", e[7:0]);
          end
        end
        if (chk_spacing && sp_prev) begin
          n_chk++;
          if (cyc - last_wr != 3) begin
            n_fail++;
            $display("FAIL write_spacing: got %0d cycles required 3", cyc - last_wr);
          end
        end
        sp_prev = chk_spacing;
        last_wr = cyc;
      end
      if (!fx2_pktend_n_o) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pktend: got pktend required no strobe at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != 9'h100) begin
            n_fail++;
            $display("FAIL pktend_order: got pktend required write %02h", e[7:0]);
          end
        end
        last_pe = cyc;
      end
    end
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      a = snap_act(s.sel);
      n_chk++;
      if (a != s.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d required %0d", snap_name(s.sel), a, s.exp);
      end
    end
  end

  task automatic push_snap(input int sel, input int exp);
    snap_t s;
    s.sel = sel;
    s.exp = exp;
    snap_q.push_back(s);
  endtask

  // One clock: the FIFO model answers a request sampled before the edge with q one cycle later.
  task automatic step();
    logic r;
    @(negedge clk_i);
    r = fifo_req_o;
    @(posedge clk_i);
    #1;
    if (r && fifo_q.size() > 0) begin
      fifo_data_i = fifo_q.pop_front();
      req_seen++;
    end
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic load_byte(input logic [7:0] b, input bit expect_write);
    fifo_q.push_back(b);
    if (expect_write) exp_q.push_back({1'b0, b});
    fifo_empty_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      step();
      k++;
    end
    if (exp_q.size() > 0) push_snap(10, 0);
  endtask

  initial begin
    int k;
    int base;
    reset_i      = 1'b0;
    en_i         = 1'b0;
    fifo_empty_i = 1'b1;
    fx2_full_n_i = 1'b1;
    fifo_data_i  = 8'h00;

    // Reset hold with random inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      en_i         = 1'($urandom_range(0, 1));
      fifo_empty_i = 1'($urandom_range(0, 1));
      fx2_full_n_i = 1'($urandom_range(0, 1));
      fifo_data_i  = 8'($urandom_range(0, 255));
      if (i == 3) begin
        push_snap(0, 1);
        push_snap(1, 1);
        push_snap(2, 0);
        push_snap(3, 2);
        push_snap(4, 1);
        push_snap(5, 0);
        push_snap(6, 0);
        push_snap(7, 0);
      end
    end
    en_i         = 1'b0;
    fifo_empty_i = 1'b1;
    fx2_full_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    step();

    // Full 512-byte packet, auto-commit, 3-cycle spacing
    chk_spacing = 1'b1;
    for (int i = 0; i < PKT; i++) load_byte(8'(i), 1'b1);
    en_i = 1'b1;
    wait_drain(2000);
    chk_spacing = 1'b0;
    for (int i = 0; i < 4; i++) step();
    push_snap(5, 1);
    push_snap(6, 0);
    step();

    // 10-byte partial packet flushed by the idle timeout
    for (int i = 0; i < 10; i++) load_byte(8'h30 + 8'(i), 1'b1);
    exp_q.push_back(9'h100);
    wait_drain(500);
    push_snap(8, TMO + 1);
    push_snap(5, 2);
    push_snap(6, 0);
    step();

    // FLAGB low while 0xA5 sits in WRITE
    load_byte(8'hA5, 1'b1);
    exp_q.push_back(9'h100);
    k = 0;
    while (!fifo_req_o && k < 50) begin
      step();
      k++;
    end
    step();                 // now in FETCH
    fx2_full_n_i = 1'b0;
    step();                 // now in WRITE, stalled
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 19) begin
        push_snap(0, 1);
        push_snap(7, 8'hA5);
      end
      step();
    end
    fx2_full_n_i = 1'b1;
    wait_drain(200);
    push_snap(8, TMO + 1);
    push_snap(5, 3);
    step();

    // en_i drops during the 8th FETCH: byte 8 completes, then immediate PKTEND
    for (int i = 0; i < 10; i++) load_byte(8'h50 + 8'(i), i < 8);
    exp_q.push_back(9'h100);
    base = req_seen;
    k = 0;
    while (!((req_seen - base == 7) && fifo_req_o) && k < 200) begin
      step();
      k++;
    end
    step();                 // now in FETCH of byte 8
    en_i = 1'b0;
    wait_drain(100);
    push_snap(8, 2);
    push_snap(5, 4);
    for (int i = 0; i < 5; i++) step();
    push_snap(9, PKT + 10 + 1 + 8);
    step();
    fifo_q.delete();
    fifo_empty_i = 1'b1;

    // Enabled with an empty FIFO and nothing pending: no activity
    en_i = 1'b1;
    for (int i = 0; i < 10000; i++) step();
    push_snap(9, PKT + 10 + 1 + 8);
    push_snap(11, PKT + 10 + 1 + 8);
    push_snap(5, 4);
    push_snap(6, 0);
    push_snap(10, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
